sar_adc_controller: RTL and testbench

Successive-approximation controller that closes the loop around the 3.3 V analog comparator and a binary-weighted DAC. It drives the comparator enable and the DAC trial code, samples the comparator's digital output once per bit, and produces an N-bit conversion result. It sits in the digital domain next to the analog comparator and is controlled by the SoC's memory-mapped ADC peripheral logic.

---
 rtl/sar_adc_controller_if.sv | 24 ++
 rtl/sar_adc_controller.sv | 115 +++++++++++
 tb/tb_sar_adc_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sar_adc_controller_if.sv
// Handshake and analog-loop signals between the ADC peripheral logic and the SAR controller.
// master = peripheral/comparator side, slave = controller side.
interface sar_adc_controller_if #(
   parameter int unsigned WIDTH = 10
);
   logic             start;
   logic             abort;
   logic             cmp_out;
   logic             cmp_en;
   logic [WIDTH-1:0] dac_code;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, abort, cmp_out,
      input  cmp_en, dac_code, busy, done, result
   );

   modport slave (
      input  start, abort, cmp_out,
      output cmp_en, dac_code, busy, done, result
   );
endinterface

// File: rtl/sar_adc_controller.sv
// Successive-approximation controller: MSB-first binary search of the DAC code
// against the comparator, with a settle window before every decision.
module sar_adc_controller #(
   parameter int unsigned WIDTH         = 10,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input logic                 clk,
   input logic                 resetn,
   sar_adc_controller_if.slave bus
);
   localparam int unsigned BW = $clog2(WIDTH);
   localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [BW-1:0] MSB_IDX  = BW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DECIDE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] dac_q, dac_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] trial;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         dac_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         dac_q   <= dac_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      dac_d   = dac_q;
      res_d   = res_q;
      done_d  = 1'b0;
      trial   = dac_q;

      case (state_q)
         IDLE: begin
            // abort outranks a coincident start
            if (bus.start && !bus.abort) begin
               bit_d          = MSB_IDX;
               dac_d          = '0;
               dac_d[MSB_IDX] = 1'b1;
               cnt_d          = CNT_LOAD;
               state_d        = SETTLE;
            end
         end

         SETTLE: begin
            if (bus.abort) begin
               dac_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = DECIDE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         DECIDE: begin
            if (bus.abort) begin
               dac_d   = '0;
               state_d = IDLE;
            end else begin
               if (!bus.cmp_out) begin
                  trial[bit_q] = 1'b0;
               end
               if (bit_q != '0) begin
                  trial[bit_q - 1'b1] = 1'b1;
                  dac_d   = trial;
                  bit_d   = bit_q - 1'b1;
                  cnt_d   = CNT_LOAD;
                  state_d = SETTLE;
               end else begin
                  res_d   = trial;
                  done_d  = 1'b1;
                  dac_d   = '0;
                  state_d = IDLE;
               end
            end
         end

         default: begin
            dac_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.cmp_en   = (state_q != IDLE);
   assign bus.dac_code = dac_q;
   assign bus.done     = done_q;
   assign bus.result   = res_q;
endmodule

// File: tb/tb_sar_adc_controller.sv
// Self-checking bench for sar_adc_controller: ideal comparator model plus a
// scoreboard of expected results and completion edges.
module tb_sar_adc_controller;
   localparam int unsigned W = 10;
   localparam int unsigned S = 2;
   localparam int unsigned CONV = W * (S + 1);

   typedef struct {
      logic [W-1:0] res;
      int unsigned  due;
   } exp_t;

   logic         clk = 1'b0;
   logic         resetn;
   logic [W-1:0] target;
   int unsigned  cyc = 0;
   int unsigned  n_tests = 0;
   int unsigned  n_fail = 0;
   exp_t         sb[$];

   sar_adc_controller_if #(.WIDTH(W)) bus ();

   sar_adc_controller #(
      .WIDTH(W),
      .SETTLE_CYCLES(S)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // comparator: high when the analog input is at or above the DAC level
   assign bus.cmp_out = (bus.dac_code <= target);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         check("done_expected", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("result", 32'(bus.result), 32'(e.res));
            check("done_edge", cyc, e.due);
         end
      end
   end

   task automatic begin_conv(input logic [W-1:0] t, input bit expect_done);
      target    = t;
      bus.start = 1'b1;
      if (expect_done) sb.push_back('{res: t, due: cyc + 1 + CONV});
      tick();
      bus.start = 1'b0;
   endtask

   task automatic run_conv(input logic [W-1:0] t);
      begin_conv(t, 1'b1);
      check("busy_e0", 32'(bus.busy), 1);
      for (int e = 1; e < int'(CONV); e++) begin
         tick();
         check("busy_mid", 32'(bus.busy & bus.cmp_en), 1);
      end
      tick();
      check("busy_end", 32'(bus.busy | bus.cmp_en), 0);
      check("done_end", 32'(bus.done), 1);
      check("dac_end", 32'(bus.dac_code), 0);
   endtask

   task automatic mid_op_cancel(input bit use_reset);
      begin_conv(10'h100, 1'b0);
      for (int e = 1; e < 12; e++) tick();
      if (use_reset) resetn = 1'b0;
      else bus.abort = 1'b1;
      tick();
      resetn    = 1'b1;
      bus.abort = 1'b0;
      check("cancel_busy", 32'(bus.busy), 0);
      check("cancel_cmp_en", 32'(bus.cmp_en), 0);
      check("cancel_dac", 32'(bus.dac_code), 0);
      check("cancel_result", 32'(bus.result), use_reset ? 32'h0 : 32'h2A5);
      for (int e = 0; e < int'(CONV) + 5; e++) tick();
      check("cancel_idle", 32'(bus.busy), 0);
   endtask

   initial begin
      logic [W-1:0] trials [10];
      trials = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0,
                 10'h2B0, 10'h2A8, 10'h2A4, 10'h2A6, 10'h2A5};
      resetn    = 1'b0;
      bus.start = 1'b1;
      bus.abort = 1'b0;
      target    = '0;

      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_busy", 32'(bus.busy | bus.cmp_en | bus.done), 0);
         check("rst_dac", 32'(bus.dac_code), 0);
         check("rst_result", 32'(bus.result), 0);
      end

      // first start edge after release, with the full trial-code trace
      resetn = 1'b1;
      begin_conv(10'h2A5, 1'b1);
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < int'(S) + 1; j++) begin
            check("trial", 32'(bus.dac_code), 32'(trials[i]));
            tick();
         end
      end
      check("t1_done", 32'(bus.done), 1);
      check("t1_busy", 32'(bus.busy), 0);
      tick();
      check("t1_done_pulse", 32'(bus.done), 0);

      run_conv(10'h000);
      run_conv(10'h3FF);

      // starts during a conversion are ignored; start in the done cycle is taken
      begin_conv(10'h0F0, 1'b1);
      for (int e = 1; e <= int'(CONV); e++) begin
         bus.start = (e == 5 || e == 17);
         tick();
      end
      bus.start = 1'b0;
      check("hs_done", 32'(bus.done), 1);
      run_conv(10'h155);

      // abort beats a simultaneous start in IDLE
      tick();
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("abort_vs_start", 32'(bus.busy), 0);

      run_conv(10'h2A5);
      tick();
      mid_op_cancel(1'b0);
      mid_op_cancel(1'b1);

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
